// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and error codes for the instruction memory loader.
package imem_loader_pkg;
  typedef enum logic [2:0] {LEN_HI, LEN_LO, RECV, WRITE, DONE, ERROR} state_t;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_SIZE = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: big-endian shift buffer that assembles 32-bit words from a byte stream.
module byte_packer (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  byteIn,
  output logic [31:0] word,
  output logic        lastByte
);
  logic [23:0] buffer;
  logic [1:0] byteIdx;
  // word already includes the byte being offered, so it is valid on the 4th accept
  assign word = {buffer, byteIn};
  assign lastByte = byteIdx == 2'd3;
  always_ff @(posedge CLK or negedge Reset)
    if (!Reset) begin
      buffer <= '0;
      byteIdx <= '0;
    end else if (clear) begin
      byteIdx <= '0;
    end else if (shift) begin
      buffer <= word[23:0];
      byteIdx <= byteIdx + 2'd1;
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed byte image and writes it into instruction memory,
// holding the CPU until the image is complete.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 128,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        reload,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [15:0] words_loaded,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state, nextState;
  logic [15:0] count, newCount;
  logic [CW-1:0] idleCnt;
  logic [1:0] nextErr;
  logic [31:0] word;
  logic accept, timedOut, lastByte, finished, reloadGo;
  assign in_ready = Reset && (state == LEN_HI || state == LEN_LO || state == RECV);
  assign accept = in_valid && in_ready;
  // an accept in the same cycle as the limit is reached takes priority
  assign timedOut = !accept && idleCnt == CW'(TIMEOUT - 1);
  assign newCount = {count[15:8], in_data};
  assign finished = words_loaded + 16'd1 == count;
  assign reloadGo = reload && (state == DONE || state == ERROR);
  assign cpu_hold = state != DONE;
  assign done = state == DONE;
  assign err = state == ERROR;
  byte_packer packer (
    .CLK(CLK),
    .Reset(Reset),
    .clear(state == LEN_LO),
    .shift(accept && state == RECV),
    .byteIn(in_data),
    .word(word),
    .lastByte(lastByte)
  );
  always_comb begin
    nextState = state;
    nextErr = err_code;
    case (state)
      LEN_HI: nextState = accept ? LEN_LO : LEN_HI;
      LEN_LO: nextState = accept ? (newCount == 16'd0 ? DONE : 32'(newCount) > DEPTH_WORDS ? ERROR : RECV)
                                 : (timedOut ? ERROR : LEN_LO);
      RECV: nextState = accept ? (lastByte ? WRITE : RECV) : (timedOut ? ERROR : RECV);
      WRITE: nextState = finished ? DONE : RECV;
      DONE, ERROR: nextState = reloadGo ? LEN_HI : state;
      default: nextState = LEN_HI;
    endcase
    if (nextState == ERROR && state != ERROR) nextErr = accept ? ERR_SIZE : ERR_TIMEOUT;
    if (reloadGo) nextErr = ERR_NONE;
  end
  always_ff @(posedge CLK or negedge Reset)
    if (!Reset) begin
      state <= LEN_HI;
      count <= '0;
      idleCnt <= '0;
      mem_we <= 1'b0;
      mem_addr <= BASE_ADDR;
      mem_wdata <= '0;
      words_loaded <= '0;
      err_code <= ERR_NONE;
    end else begin
      state <= nextState;
      err_code <= nextErr;
      idleCnt <= (accept || !(state == LEN_LO || state == RECV)) ? '0 : idleCnt + 1'b1;
      if (accept && state == LEN_HI) count[15:8] <= in_data;
      if (accept && state == LEN_LO) count[7:0] <= in_data;
      mem_we <= nextState == WRITE;
      if (nextState == WRITE) begin
        mem_addr <= BASE_ADDR + {14'b0, words_loaded, 2'b00};
        mem_wdata <= word;
      end
      if (state == WRITE) words_loaded <= words_loaded + 16'd1;
      else if (reloadGo) words_loaded <= '0;
    end
endmodule
